barrel_thread_fetch_sched: RTL and testbench

// Front-end slot scheduler for the NUM_THREADS-way barrel core. It holds one PC
// per hardware thread and rotates a slot pointer round-robin. Each accepted slot

---
 rtl/barrel_thread_fetch_sched.sv | 156 +++++++++++++++
 tb/tb_barrel_thread_fetch_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_fetch_sched.sv
// Barrel-core front-end: one PC/run bit per hardware thread and a round-robin slot
// pointer that presents {tid, pc} to instruction fetch over a valid/ready handshake.

module barrel_thread_ctx #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       TID_WIDTH     = 3,
    parameter int                       THREAD_ID     = 0,
    parameter logic [ADDRESS_WIDTH-1:0] INIT_PC       = '0,
    parameter logic                     INIT_ACTIVE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [TID_WIDTH-1:0]     redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt_valid,
    input  logic [TID_WIDTH-1:0]     halt_tid,
    input  logic                     resume_valid,
    input  logic [TID_WIDTH-1:0]     resume_tid,
    input  logic [ADDRESS_WIDTH-1:0] resume_pc,
    input  logic                     issue,
    output logic [ADDRESS_WIDTH-1:0] pc_eff,
    output logic                     active_eff,
    output logic                     active
);
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     active_q, active_d;
    logic                     redirect_hit, halt_hit, resume_hit;

    assign redirect_hit = redirect_valid && (redirect_tid == TID_WIDTH'(THREAD_ID));
    assign halt_hit     = halt_valid && (halt_tid == TID_WIDTH'(THREAD_ID));
    assign resume_hit   = resume_valid && (resume_tid == TID_WIDTH'(THREAD_ID));
    assign active       = active_q;

    // Halt suppresses a same-cycle resume entirely; resume overrides redirect.
    always_comb begin
        pc_eff     = pc_q;
        active_eff = active_q;
        if (redirect_hit) pc_eff = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        if (halt_hit) begin
            active_eff = 1'b0;
        end else if (resume_hit) begin
            active_eff = 1'b1;
            pc_eff     = {resume_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end
        pc_d     = (issue && active_eff) ? pc_eff + ADDRESS_WIDTH'(4) : pc_eff;
        active_d = active_eff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= INIT_PC;
            active_q <= INIT_ACTIVE;
        end else begin
            pc_q     <= pc_d;
            active_q <= active_d;
        end
    end
endmodule

module barrel_thread_fetch_sched #(
    parameter int                       NUM_THREADS   = 8,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       TID_WIDTH     = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = 'h100,
    parameter logic [NUM_THREADS-1:0]   ACTIVE_RESET  = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [TID_WIDTH-1:0]     fetch_tid,
    output logic [ADDRESS_WIDTH-1:0] fetch_pc,
    input  logic                     redirect_valid,
    input  logic [TID_WIDTH-1:0]     redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt_valid,
    input  logic [TID_WIDTH-1:0]     halt_tid,
    input  logic                     resume_valid,
    input  logic [TID_WIDTH-1:0]     resume_tid,
    input  logic [ADDRESS_WIDTH-1:0] resume_pc,
    output logic [NUM_THREADS-1:0]   thread_active,
    output logic                     all_halted
);
    logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] pc_eff;
    logic [NUM_THREADS-1:0]                    active_eff;
    logic [NUM_THREADS-1:0]                    issue;

    logic [TID_WIDTH-1:0]     slot_q, slot_d;
    logic                     fetch_valid_q, fetch_valid_d;
    logic [TID_WIDTH-1:0]     fetch_tid_q, fetch_tid_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     consume;

    // A bubble never blocks: the slot advances whenever nothing valid is pending.
    assign consume = fetch_ready || !fetch_valid_q;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        assign issue[t] = consume && (slot_q == TID_WIDTH'(t));
        barrel_thread_ctx #(
            .ADDRESS_WIDTH(ADDRESS_WIDTH),
            .TID_WIDTH    (TID_WIDTH),
            .THREAD_ID    (t),
            .INIT_PC      (RESET_PC + ADDRESS_WIDTH'(t) * PC_STRIDE),
            .INIT_ACTIVE  (ACTIVE_RESET[t])
        ) u_ctx (
            .clk           (clk),
            .rst           (rst),
            .redirect_valid(redirect_valid),
            .redirect_tid  (redirect_tid),
            .redirect_pc   (redirect_pc),
            .halt_valid    (halt_valid),
            .halt_tid      (halt_tid),
            .resume_valid  (resume_valid),
            .resume_tid    (resume_tid),
            .resume_pc     (resume_pc),
            .issue         (issue[t]),
            .pc_eff        (pc_eff[t]),
            .active_eff    (active_eff[t]),
            .active        (thread_active[t])
        );
    end

    always_comb begin
        slot_d        = slot_q;
        fetch_valid_d = fetch_valid_q;
        fetch_tid_d   = fetch_tid_q;
        fetch_pc_d    = fetch_pc_q;
        if (consume) begin
            slot_d        = slot_q + TID_WIDTH'(1);
            fetch_valid_d = active_eff[slot_q];
            fetch_tid_d   = slot_q;
            fetch_pc_d    = pc_eff[slot_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q        <= '0;
            fetch_valid_q <= 1'b0;
            fetch_tid_q   <= '0;
            fetch_pc_q    <= '0;
        end else begin
            slot_q        <= slot_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_tid_q   <= fetch_tid_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_tid   = fetch_tid_q;
    assign fetch_pc    = fetch_pc_q;
    assign all_halted  = ~|thread_active;
endmodule

// File: tb/tb_barrel_thread_fetch_sched.sv
// Directed bench for barrel_thread_fetch_sched: rotation, halt/resume, redirect
// bypass, stall hold, all-halted and asynchronous reset mid-stall.
module tb_barrel_thread_fetch_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [2:0]  fetch_tid;
    logic [31:0] fetch_pc;
    logic        redirect_valid;
    logic [2:0]  redirect_tid;
    logic [31:0] redirect_pc;
    logic        halt_valid;
    logic [2:0]  halt_tid;
    logic        resume_valid;
    logic [2:0]  resume_tid;
    logic [31:0] resume_pc;
    logic [7:0]  thread_active;
    logic        all_halted;

    int          tests = 0;
    int          fails = 0;
    string       phase = "reset";
    int          exp_slot;
    logic [7:0]  exp_act;
    logic [31:0] exp_pc [8];
    logic [31:0] exp_last_pc;

    always #5 clk = ~clk;

    barrel_thread_fetch_sched dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_tid(fetch_tid), .fetch_pc(fetch_pc),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .resume_valid(resume_valid), .resume_tid(resume_tid), .resume_pc(resume_pc),
        .thread_active(thread_active), .all_halted(all_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        exp_slot = 0;
        exp_act  = 8'hff;
        for (int t = 0; t < 8; t++) exp_pc[t] = 32'(t) * 32'h100;
    endtask

    // Advance n consumed slots, checking each issued slot against the expected state.
    task automatic round(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("tid", 32'(fetch_tid), 32'(exp_slot));
            chk("valid", 32'(fetch_valid), 32'(exp_act[exp_slot]));
            if (exp_act[exp_slot]) begin
                chk("pc", fetch_pc, exp_pc[exp_slot]);
                exp_last_pc      = exp_pc[exp_slot];
                exp_pc[exp_slot] = exp_pc[exp_slot] + 32'd4;
            end
            exp_slot = (exp_slot + 1) % 8;
        end
    endtask

    initial begin
        rst = 1'b0; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
        halt_valid = 1'b0; halt_tid = '0;
        resume_valid = 1'b0; resume_tid = '0; resume_pc = '0;
        reset_model();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_tid", 32'(fetch_tid), 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_active", 32'(thread_active), 32'hff);
        chk("rst_allh", 32'(all_halted), 32'd0);
        rst = 1'b1;

        phase = "rotate";
        round(16);

        phase = "halt3";
        halt_valid = 1'b1; halt_tid = 3'd3; exp_act[3] = 1'b0;
        round(1);
        halt_valid = 1'b0;
        round(15);
        chk("active_h3", 32'(thread_active), 32'hf7);

        phase = "resume3";
        resume_valid = 1'b1; resume_tid = 3'd3; resume_pc = 32'h2000;
        exp_act[3] = 1'b1; exp_pc[3] = 32'h2000;
        round(1);
        resume_valid = 1'b0;
        round(15);

        phase = "redirect5";
        round(5);
        redirect_valid = 1'b1; redirect_tid = 3'd5; redirect_pc = 32'h40;
        exp_pc[5] = 32'h40;
        round(1);
        redirect_valid = 1'b0;
        round(10);

        phase = "stall";
        fetch_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                redirect_valid = 1'b1; redirect_tid = 3'd1; redirect_pc = 32'h1237;
            end
            @(posedge clk);
            @(negedge clk);
            redirect_valid = 1'b0;
            chk("stall_tid", 32'(fetch_tid), 32'd7);
            chk("stall_pc", fetch_pc, exp_last_pc);
            chk("stall_valid", 32'(fetch_valid), 32'd1);
        end
        exp_pc[1] = 32'h1234;
        fetch_ready = 1'b1;
        round(8);

        phase = "halt_resume_same";
        halt_valid = 1'b1; halt_tid = 3'd2;
        resume_valid = 1'b1; resume_tid = 3'd2; resume_pc = 32'h3000;
        exp_act[2] = 1'b0;
        round(1);
        halt_valid = 1'b0; resume_valid = 1'b0;
        round(7);
        redirect_valid = 1'b1; redirect_tid = 3'd2; redirect_pc = 32'h500;
        exp_pc[2] = 32'h500;
        round(1);
        redirect_valid = 1'b0;
        round(7);
        chk("active_h2", 32'(thread_active), 32'hfb);

        phase = "halt_all";
        for (int i = 0; i < 8; i++) begin
            halt_valid = 1'b1; halt_tid = 3'(i); exp_act[i] = 1'b0;
            round(1);
        end
        halt_valid = 1'b0;
        chk("allh_set", 32'(all_halted), 32'd1);
        chk("active_none", 32'(thread_active), 32'd0);
        round(14);
        resume_valid = 1'b1; resume_tid = 3'd6; resume_pc = 32'hffff_fffc;
        exp_act[6] = 1'b1; exp_pc[6] = 32'hffff_fffc;
        round(1);
        resume_valid = 1'b0;
        chk("allh_clr", 32'(all_halted), 32'd0);
        chk("active_6", 32'(thread_active), 32'h40);
        round(8);
        chk("pc_wrap", fetch_pc, 32'd0);

        phase = "reset_stall";
        fetch_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("pre_rst_valid", 32'(fetch_valid), 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(fetch_valid), 32'd0);
        chk("async_tid", 32'(fetch_tid), 32'd0);
        chk("async_pc", fetch_pc, 32'd0);
        chk("async_active", 32'(thread_active), 32'hff);
        @(negedge clk);
        rst = 1'b1; fetch_ready = 1'b1;
        reset_model();
        round(16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
